// File: rtl/key_uart_ctrl.sv
// Purpose : round-robin arbiter that turns key press events into two-byte UART reports (ID, count).
// Latency : a request sampled in IDLE raises tx_fs at the same edge; report = 3 + T1 + T2 cycles.
// Backpres: each byte is held on tx_data with tx_fs high until tx_fd; other keys wait on their own fs.
// Ports   : clk/rst (async active-high), key_fs/key_fd (per-key request/done),
//           tx_fs/tx_fd/tx_data (UART start/done/byte), busy (not IDLE), gnt_id (current/last grant).
module key_uart_ctrl #(
  parameter int          NUM_KEY   = 4,
  parameter logic [7:0]  BASE_CHAR = 8'h30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_KEY-1:0] key_fs,
  output logic [NUM_KEY-1:0] key_fd,
  output logic               tx_fs,
  input  logic               tx_fd,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [2:0]         gnt_id
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TX_ID  = 3'd1,
    S_GAP    = 3'd2,
    S_TX_CNT = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [2:0]         r_gnt;
  logic [7:0]         r_cnt [8];
  logic [NUM_KEY-1:0] r_key_fd;
  logic               r_tx_fs;
  logic [7:0]         r_tx_data;
  logic               r_busy;

  logic [7:0]         w_req;
  logic [2:0]         w_idx;
  logic [2:0]         w_sel;
  logic               w_any;
  logic [2:0]         w_ptr_nxt;

  // Round-robin pick: scan from the highest offset down so the last hit
  // is the first set bit at or above r_ptr (with wrap).
  always_comb begin
    w_req = '0;
    w_req[NUM_KEY-1:0] = key_fs;
    w_idx = '0;
    w_sel = '0;
    for (int k = NUM_KEY - 1; k >= 0; k--) begin
      w_idx = 3'((int'(r_ptr) + k) % NUM_KEY);
      if (w_req[w_idx]) begin
        w_sel = w_idx;
      end
    end
  end

  assign w_any     = |key_fs;
  assign w_ptr_nxt = (r_gnt == 3'(NUM_KEY - 1)) ? 3'd0 : r_gnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_key_fd  <= '0;
      r_tx_fs   <= 1'b0;
      r_tx_data <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt        <= w_sel;
            r_cnt[w_sel] <= r_cnt[w_sel] + 8'd1;
            r_tx_fs      <= 1'b1;
            r_tx_data    <= BASE_CHAR + {5'd0, w_sel};
            r_busy       <= 1'b1;
            r_state      <= S_TX_ID;
          end
        end
        S_TX_ID: begin
          if (tx_fd) begin
            r_tx_fs   <= 1'b0;
            r_tx_data <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          // One low cycle so the TX block sees a fresh rising edge.
          r_tx_fs   <= 1'b1;
          r_tx_data <= r_cnt[r_gnt];
          r_state   <= S_TX_CNT;
        end
        S_TX_CNT: begin
          if (tx_fd) begin
            r_tx_fs   <= 1'b0;
            r_tx_data <= '0;
            for (int i = 0; i < NUM_KEY; i++) begin
              r_key_fd[i] <= (r_gnt == 3'(i));
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_key_fd <= '0;
          r_ptr    <= w_ptr_nxt;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_key_fd  <= '0;
          r_tx_fs   <= 1'b0;
          r_tx_data <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign key_fd  = r_key_fd;
  assign tx_fs   = r_tx_fs;
  assign tx_data = r_tx_data;
  assign busy    = r_busy;
  assign gnt_id  = r_gnt;

endmodule
